// File: rtl/fp_mul_issue.sv
// Issue/collect stage in front of the FSM-based single-precision FP multiplier.
// Buffers operand pairs, runs one multiply at a time in order, and watchdogs a silent multiplier.
module fp_mul_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err,
    output logic [15:0] done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    logic [31:0]   mem_a_r [DEPTH];
    logic [31:0]   mem_b_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    logic [TW-1:0] wait_cnt_r;
    logic          push_s;
    logic          pop_s;

    assign in_ready = (count_r != FULL_CNT);
    assign push_s   = in_valid && in_ready;
    assign pop_s    = (state_r == ST_IDLE) && (count_r != {CW{1'b0}});
    assign busy     = (state_r != ST_IDLE) || (count_r != {CW{1'b0}});

    // Operand FIFO storage, power-of-two pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i] <= 32'h0;
                mem_b_r[i] <= 32'h0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_a_r[wr_ptr_r] <= in_a;
                mem_b_r[wr_ptr_r] <= in_b;
                wr_ptr_r          <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM: pop head, pulse start, wait for done or watchdog, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {TW{1'b0}};
            mul_start  <= 1'b0;
            mul_a      <= 32'h0;
            mul_b      <= 32'h0;
            out_valid  <= 1'b0;
            out_data   <= 32'h0;
            err        <= 1'b0;
            done_cnt   <= 16'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mul_start <= 1'b0;
                    if (pop_s) begin
                        mul_a     <= mem_a_r[rd_ptr_r];
                        mul_b     <= mem_b_r[rd_ptr_r];
                        mul_start <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_start  <= 1'b0;
                    wait_cnt_r <= {TW{1'b0}};
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        out_data  <= mul_result;
                        out_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else if (wait_cnt_r == TMO_LAST) begin
                        // Multiplier went silent: hand back a quiet NaN and latch the error
                        err       <= 1'b1;
                        out_data  <= QNAN;
                        out_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mul_start <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_issue.sv
// Scoreboard bench for fp_mul_issue with a behavioural multiplier (7-cycle normal, 1-cycle zero operand).
module tb_fp_mul_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        err;
    logic [15:0] done_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] sb_q [$];
    logic [63:0] iq_q [$];

    int          pend = 0;
    logic [31:0] res_hold = 32'h0;
    logic [31:0] cap_a = 32'h0;
    logic [31:0] cap_b = 32'h0;
    logic        never_done = 1'b0;
    logic        late_pulse = 1'b0;
    logic        unstable = 1'b0;

    always #5 clk = ~clk;

    fp_mul_issue #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err), .done_cnt(done_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Hand-computed products for the directed operand pairs
    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: mul_ref = 32'h40C00000;
            {32'h80000000, 32'h3F800000}: mul_ref = 32'h80000000;
            {32'h3F800000, 32'h3F800000}: mul_ref = 32'h3F800000;
            {32'h40000000, 32'h40000000}: mul_ref = 32'h40800000;
            {32'h3FC00000, 32'h40000000}: mul_ref = 32'h40400000;
            {32'h40400000, 32'h40400000}: mul_ref = 32'h41100000;
            {32'h40800000, 32'h3F000000}: mul_ref = 32'h40000000;
            {32'h3F800000, 32'h40000000}: mul_ref = 32'h40000000;
            default:                      mul_ref = 32'hDEADBEEF;
        endcase
    endfunction

    // Behavioural multiplier: checks issue order and operand stability, answers after its latency
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            pend     = 0;
            mul_done = 1'b0;
        end else begin
            mul_done = 1'b0;
            if (late_pulse) begin
                mul_done   = 1'b1;
                late_pulse = 1'b0;
            end
            if (pend > 0) begin
                if (mul_a !== cap_a || mul_b !== cap_b) unstable = 1'b1;
                pend--;
                if (pend == 0) begin
                    mul_done   = 1'b1;
                    mul_result = res_hold;
                    chk("operands_stable", 32'(unstable), 32'd0);
                end
            end
            if (mul_start) begin
                if (iq_q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = iq_q.pop_front();
                    chk("issue_a", mul_a, e[63:32]);
                    chk("issue_b", mul_b, e[31:0]);
                end
                cap_a    = mul_a;
                cap_b    = mul_b;
                unstable = 1'b0;
                res_hold = mul_ref(mul_a, mul_b);
                if (!never_done)
                    pend = (mul_a[30:0] == 31'd0 || mul_b[30:0] == 31'd0) ? 1 : 7;
            end
        end
    end

    // Output monitor: compare each accepted product with the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("unexpected_output", out_data, 32'hFFFFFFFF);
            else chk("out_data", out_data, sb_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the pair is accepted
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int g = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        chk("push_accepted", 32'(in_ready), 32'd1);
        iq_q.push_back({a, b});
        sb_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int g = 0;
        @(negedge clk);
        while (!mul_start && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("start_seen", 32'(mul_start), 32'd1);
    endtask

    task automatic cycles_to_valid(output int k, output logic stray);
        k     = 0;
        stray = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (mul_start) stray = 1'b1;
        end while (!out_valid && k < 100);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((busy || out_valid || sb_q.size() != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("drained", 32'(sb_q.size()), 32'd0);
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        chk({tag, "_mul_a"}, mul_a, 32'h0);
        chk({tag, "_mul_b"}, mul_b, 32'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   k;
        logic stray;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = 32'h0;
        in_b       = 32'h0;
        out_ready  = 1'b0;
        mul_done   = 1'b0;
        mul_result = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 2.0*3.0, single start pulse two edges after the push, 7-cycle multiply
        out_ready = 1'b1;
        push(32'h40000000, 32'h40400000, 32'h40C00000);
        @(negedge clk);
        chk("t1_start_not_early", 32'(mul_start), 32'd0);
        @(negedge clk);
        chk("t1_start_pulse", 32'(mul_start), 32'd1);
        cycles_to_valid(k, stray);
        chk("t1_latency", 32'(k), 32'd8);
        chk("t1_single_start", 32'(stray), 32'd0);
        wait_idle();
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // 2: back-pressure fills one in flight plus four queued
        @(posedge clk); #1;
        out_ready = 1'b0;
        push(32'h3F800000, 32'h3F800000, 32'h3F800000);
        push(32'h40000000, 32'h40000000, 32'h40800000);
        push(32'h3FC00000, 32'h40000000, 32'h40400000);
        push(32'h40400000, 32'h40400000, 32'h41100000);
        push(32'h40800000, 32'h3F000000, 32'h40000000);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a     = 32'h40A00000;
        in_b     = 32'h40000000;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_still_full", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("t2_done_cnt", 32'(done_cnt), 32'd6);

        // 3: zero operand, 1-cycle multiply, out_valid one cycle after done
        @(posedge clk); #1;
        push(32'h80000000, 32'h3F800000, 32'h80000000);
        wait_start();
        cycles_to_valid(k, stray);
        chk("t3_latency", 32'(k), 32'd2);
        wait_idle();
        chk("t3_done_cnt", 32'(done_cnt), 32'd7);

        // 4: silent multiplier, watchdog, late done ignored, next op still served
        @(posedge clk); #1;
        out_ready  = 1'b0;
        never_done = 1'b1;
        push(32'h3F800000, 32'h40000000, 32'h7FC00000);
        wait_start();
        cycles_to_valid(k, stray);
        chk("t4_timeout_cycles", 32'(k), 32'd16);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_qnan", out_data, 32'h7FC00000);
        @(posedge clk); #1;
        late_pulse = 1'b1;
        never_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_late_done_data", out_data, 32'h7FC00000);
        chk("t4_late_done_valid", 32'(out_valid), 32'd1);
        chk("t4_no_restart", 32'(mul_start), 32'd0);
        @(posedge clk); #1;
        push(32'h40000000, 32'h40400000, 32'h40C00000);
        out_ready = 1'b1;
        wait_idle();
        chk("t4_done_cnt", 32'(done_cnt), 32'd9);
        chk("t4_err_sticky", 32'(err), 32'd1);

        // 5: reset mid-WAIT with one queued pair
        @(posedge clk); #1;
        never_done = 1'b1;
        push(32'h3F800000, 32'h3F800000, 32'h3F800000);
        push(32'h40000000, 32'h40000000, 32'h40800000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        iq_q.delete();
        #1;
        chk_reset_state("midop_reset");
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        never_done = 1'b0;
        stray      = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || mul_start) stray = 1'b1;
        end
        chk("t5_quiet_after_reset", 32'(stray), 32'd0);
        chk("t5_fifo_empty", 32'(busy), 32'd0);

        // 6: FIFO at two entries, push and pop on the same edge
        @(posedge clk); #1;
        out_ready = 1'b0;
        push(32'h40000000, 32'h40000000, 32'h40800000);
        push(32'h3FC00000, 32'h40000000, 32'h40400000);
        push(32'h40400000, 32'h40400000, 32'h41100000);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t6_first_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = 32'h3F800000;
        in_b     = 32'h40000000;
        iq_q.push_back({32'h3F800000, 32'h40000000});
        sb_q.push_back(32'h40000000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_pop_same_edge", 32'(mul_start), 32'd1);
        wait_idle();
        chk("t6_done_cnt", 32'(done_cnt), 32'd4);
        chk("t6_issue_drained", 32'(iq_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
